// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-layer sequencers and their popcount datapath.
package bnn_pkg;

    localparam int POPCNT_W  = 11;
    localparam int TAG_IDX_W = 16;
    localparam int TAG_TH_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // Fields are sized for the largest layer; controllers narrow them with casts.
    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_IDX_W-1:0] neuron;
        logic [TAG_TH_W-1:0]  thresh;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/bnn_tag_pipe.sv
// Depth-D shift register carrying a valid bit and a W-bit tag; only the valid chain is cleared.
module bnn_tag_pipe #(
    parameter int D = 3,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld_in,
    input  logic [W-1:0] data_in,
    output logic         vld_out,
    output logic [W-1:0] data_out,
    output logic         occupied
);

    if (D == 0) begin : g_bypass
        assign vld_out  = vld_in;
        assign data_out = data_in;
        assign occupied = 1'b0;
    end else begin : g_shift
        logic [D-1:0] vld_q;
        logic [W-1:0] data_q [D];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= vld_in;
                for (int i = 1; i < D; i++) vld_q[i] <= vld_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            data_q[0] <= data_in;
            for (int i = 1; i < D; i++) data_q[i] <= data_q[i-1];
        end

        assign vld_out  = vld_q[D-1];
        assign data_out = data_q[D-1];
        assign occupied = |vld_q;
    end

endmodule

// File: rtl/bnn_layer_ctrl.sv
// Sequencer for one binary fully-connected layer: walks (neuron, chunk), feeds the
// xnor-popcount datapath, accumulates per neuron and emits one thresholded bit per neuron.
module bnn_layer_ctrl
    import bnn_pkg::*;
#(
    parameter int WL      = 112,
    parameter int CHUNKS  = 4,
    parameter int NEURONS = 64,
    parameter int PC_LAT  = 3,
    parameter int ACC_W   = $clog2(CHUNKS*WL+1),
    parameter int WA_W    = (NEURONS*CHUNKS > 1) ? $clog2(NEURONS*CHUNKS) : 1,
    parameter int XA_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    parameter int NA_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iSTART,
    output logic                oBUSY,
    output logic                oDONE,
    output logic [WA_W-1:0]     oW_ADDR,
    output logic [XA_W-1:0]     oX_ADDR,
    output logic [NA_W-1:0]     oTH_ADDR,
    output logic                oRD_EN,
    input  logic [WL-1:0]       iW_DATA,
    input  logic [WL-1:0]       iX_DATA,
    input  logic [ACC_W-1:0]    iTH_DATA,
    output logic [WL-1:0]       oPC_DATA,
    output logic [WL-1:0]       oPC_WEIGHT,
    output logic                oPC_EN,
    input  logic [POPCNT_W-1:0] iPOPCNT,
    output logic                oBIT,
    output logic [NA_W-1:0]     oBIT_IDX,
    output logic                oBIT_VALID
);

    ctrl_state_t      state_q, state_d;
    logic [XA_W-1:0]  chunk_q;
    logic [NA_W-1:0]  neuron_q;
    logic [WA_W-1:0]  waddr_q;
    logic             chunk_end, neuron_end, start_go;
    logic             rd_en, busy, done;

    logic             vld_p0, first_p0, last_p0;
    logic [NA_W-1:0]  neuron_p0;

    tag_t             tag_in, tag_out;
    logic             exit_vld, exit_go, pipe_occupied;

    logic [ACC_W-1:0] acc_q, acc_next, pc_ext;
    logic             bit_q, bit_vld_q;
    logic [NA_W-1:0]  bit_idx_q;

    assign chunk_end  = (chunk_q == XA_W'(CHUNKS - 1));
    assign neuron_end = (neuron_q == NA_W'(NEURONS - 1));
    assign start_go   = (state_q == ST_IDLE) && iSTART;

    always_ff @(posedge iCLK) begin
        if (iRST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // DRAIN ends once the final bit is on the output and nothing is left in flight.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (iSTART) state_d = ST_RUN;
            end
            ST_RUN: begin
                rd_en = 1'b1;
                if (chunk_end && neuron_end) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bit_vld_q && !vld_p0 && !pipe_occupied) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The weight address counts alongside (neuron, chunk), so it always equals neuron*CHUNKS+chunk.
    always_ff @(posedge iCLK) begin
        if (iRST || start_go) begin
            chunk_q  <= '0;
            neuron_q <= '0;
            waddr_q  <= '0;
        end else if (rd_en) begin
            if (chunk_end) begin
                chunk_q  <= '0;
                neuron_q <= neuron_end ? '0 : neuron_q + NA_W'(1);
            end else begin
                chunk_q <= chunk_q + XA_W'(1);
            end
            waddr_q <= (chunk_end && neuron_end) ? '0 : waddr_q + WA_W'(1);
        end
    end

    // Stage p0: memory read data is valid; this is also where the threshold is captured.
    always_ff @(posedge iCLK) begin
        if (iRST) vld_p0 <= 1'b0;
        else      vld_p0 <= rd_en;
    end

    always_ff @(posedge iCLK) begin
        first_p0  <= (chunk_q == '0);
        last_p0   <= chunk_end;
        neuron_p0 <= neuron_q;
    end

    always_comb begin
        tag_in        = '0;
        tag_in.valid  = vld_p0;
        tag_in.first  = first_p0;
        tag_in.last   = last_p0;
        tag_in.neuron = TAG_IDX_W'(neuron_p0);
        tag_in.thresh = last_p0 ? TAG_TH_W'(iTH_DATA) : '0;
    end

    // Remaining PC_LAT stages line each tag up with its popcount result.
    bnn_tag_pipe #(
        .D (PC_LAT),
        .W (TAG_W)
    ) u_tag_pipe (
        .clk      (iCLK),
        .rst      (iRST),
        .vld_in   (vld_p0),
        .data_in  (tag_in),
        .vld_out  (exit_vld),
        .data_out (tag_out),
        .occupied (pipe_occupied)
    );

    assign exit_go  = exit_vld && tag_out.valid;
    assign pc_ext   = ACC_W'(iPOPCNT);
    assign acc_next = tag_out.first ? pc_ext : acc_q + pc_ext;

    // Pipe exit: accumulate and, on the last chunk, register the binarized neuron output.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            acc_q     <= '0;
            bit_q     <= 1'b0;
            bit_idx_q <= '0;
            bit_vld_q <= 1'b0;
        end else begin
            bit_vld_q <= 1'b0;
            if (exit_go) begin
                acc_q <= acc_next;
                if (tag_out.last) begin
                    bit_q     <= (acc_next >= ACC_W'(tag_out.thresh));
                    bit_idx_q <= NA_W'(tag_out.neuron);
                    bit_vld_q <= 1'b1;
                end
            end
        end
    end

    assign oBUSY      = busy;
    assign oDONE      = done;
    assign oRD_EN     = rd_en;
    assign oW_ADDR    = waddr_q;
    assign oX_ADDR    = chunk_q;
    assign oTH_ADDR   = neuron_q;
    assign oPC_EN     = vld_p0;
    assign oPC_DATA   = vld_p0 ? iX_DATA : '0;
    assign oPC_WEIGHT = vld_p0 ? iW_DATA : '0;
    assign oBIT       = bit_q;
    assign oBIT_IDX   = bit_idx_q;
    assign oBIT_VALID = bit_vld_q;

endmodule

// File: tb/tb_bnn_layer_ctrl.sv
// Scoreboard bench for bnn_layer_ctrl over three layer shapes (2x2, 3x4 and 1x1 neurons x chunks).
module tb_bnn_layer_ctrl;

    localparam int WL   = 112;
    localparam int PL   = 3;
    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // cyc counts rising edges; between edge j-1 and edge j the bench is in "cycle j".
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int dir_pc [4] = '{100, 12, 0, 112};

    typedef struct {
        int idx;
        int b;
        int at;
    } exp_t;

    task automatic check(input int cfg, input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL cfg%0d %s: got %0d, expected %0d", cfg, name, act, exp);
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int N  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam int C  = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        localparam int AW = $clog2(C*WL+1);
        localparam int WA = (N*C > 1) ? $clog2(N*C) : 1;
        localparam int XA = (C > 1) ? $clog2(C) : 1;
        localparam int NA = (N > 1) ? $clog2(N) : 1;

        logic          rst, start, busy, done, rd_en, pc_en, bit_o, bit_vld;
        logic [WA-1:0] w_addr;
        logic [XA-1:0] x_addr;
        logic [NA-1:0] th_addr, bit_idx;
        logic [WL-1:0] w_data, x_data, pc_data, pc_weight;
        logic [AW-1:0] th_data;
        logic [10:0]   popcnt;

        logic [WL-1:0] wmem  [N*C];
        logic [WL-1:0] xmem  [C];
        logic [AW-1:0] thmem [N];
        logic [10:0]   pc_pipe [PL];

        exp_t sb[$];
        int   exp_done = -1;
        int   done_cnt = 0;
        bit   fin_g    = 1'b0;

        bnn_layer_ctrl #(
            .WL      (WL),
            .CHUNKS  (C),
            .NEURONS (N),
            .PC_LAT  (PL)
        ) dut (
            .iCLK       (clk),
            .iRST       (rst),
            .iSTART     (start),
            .oBUSY      (busy),
            .oDONE      (done),
            .oW_ADDR    (w_addr),
            .oX_ADDR    (x_addr),
            .oTH_ADDR   (th_addr),
            .oRD_EN     (rd_en),
            .iW_DATA    (w_data),
            .iX_DATA    (x_data),
            .iTH_DATA   (th_data),
            .oPC_DATA   (pc_data),
            .oPC_WEIGHT (pc_weight),
            .oPC_EN     (pc_en),
            .iPOPCNT    (popcnt),
            .oBIT       (bit_o),
            .oBIT_IDX   (bit_idx),
            .oBIT_VALID (bit_vld)
        );

        // Synchronous-read memories with one cycle of latency.
        always @(posedge clk) begin
            if (rd_en) begin
                w_data  <= wmem[w_addr];
                x_data  <= xmem[x_addr];
                th_data <= thmem[th_addr];
            end
        end

        // Xnor-popcount datapath with PL cycles of latency; junk when not enabled.
        always @(posedge clk) begin
            pc_pipe[0] <= pc_en ? 11'($countones(~(pc_data ^ pc_weight))) : 11'($urandom_range(2047));
            for (int i = 1; i < PL; i++) pc_pipe[i] <= pc_pipe[i-1];
        end
        assign popcnt = pc_pipe[PL-1];

        always @(negedge clk) begin
            int   cur;
            exp_t e;
            cur = cyc + 1;
            if (bit_vld) begin
                if (sb.size() == 0) begin
                    check(g, "unexpected_bit_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check(g, "bit_idx", bit_idx, e.idx);
                    check(g, "bit_value", bit_o, e.b);
                    check(g, "bit_cycle", cur, e.at);
                end
            end
            if (done) begin
                done_cnt++;
                check(g, "done_cycle", cur, exp_done);
                check(g, "done_after_all_bits", sb.size(), 0);
            end
        end

        function automatic int neuron_sum(input int n);
            int s = 0;
            for (int c = 0; c < C; c++) s += $countones(~(wmem[n*C+c] ^ xmem[c]));
            return s;
        endfunction

        function automatic logic [WL-1:0] rand_vec();
            logic [WL-1:0] v;
            for (int i = 0; i < WL; i++) v[i] = 1'($urandom);
            return v;
        endfunction

        // mode: 0 random, 1 w=x, 2 w=~x, 3 per-chunk popcounts from dir_pc.
        // th_sel >= 0 literal threshold; -1 random near the sum; -2 exact sum; -3 sum+1.
        task automatic fill(input int mode, input int th_sel);
            logic [WL-1:0] m;
            int s, th, pc;
            for (int c = 0; c < C; c++) xmem[c] = rand_vec();
            for (int n = 0; n < N; n++) begin
                for (int c = 0; c < C; c++) begin
                    case (mode)
                        1: wmem[n*C+c] = xmem[c];
                        2: wmem[n*C+c] = ~xmem[c];
                        3: begin
                            pc = dir_pc[c % 4];
                            for (int i = 0; i < WL; i++) m[i] = (i < WL - pc);
                            wmem[n*C+c] = xmem[c] ^ m;
                        end
                        default: wmem[n*C+c] = rand_vec();
                    endcase
                end
                s = neuron_sum(n);
                case (th_sel)
                    -1: th = s + int'($urandom_range(6)) - 3;
                    -2: th = s;
                    -3: th = s + 1;
                    default: th = th_sel;
                endcase
                if (th < 0) th = 0;
                if (th > C*WL) th = C*WL;
                thmem[n] = AW'(th);
            end
        endtask

        task automatic begin_layer();
            int k;
            @(negedge clk);
            start = 1'b1;
            k = cyc + 1;
            for (int n = 0; n < N; n++)
                sb.push_back('{idx: n, b: (neuron_sum(n) >= int'(thmem[n])) ? 1 : 0, at: k + 3 + PL + n*C + (C - 1)});
            exp_done = k + N*C + PL + 3;
            done_cnt = 0;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic run_layer(input bit poke);
            int waited;
            begin_layer();
            check(g, "busy_after_start", busy, 1);
            check(g, "rd_en_first_cycle", rd_en, 1);
            waited = 0;
            while (done_cnt == 0 && waited < N*C + PL + 20) begin
                start = (poke && (waited == 1 || waited == N*C + 1)) ? 1'b1 : 1'b0;
                @(negedge clk);
                waited++;
            end
            start = 1'b0;
            check(g, "done_seen", (done_cnt > 0) ? 1 : 0, 1);
            repeat (2) @(negedge clk);
            check(g, "single_done", done_cnt, 1);
            check(g, "bits_drained", sb.size(), 0);
            check(g, "idle_after_done", busy, 0);
        endtask

        task automatic check_quiet(input string tag);
            check(g, {tag, "_busy"}, busy, 0);
            check(g, {tag, "_done"}, done, 0);
            check(g, {tag, "_rd_en"}, rd_en, 0);
            check(g, {tag, "_pc_en"}, pc_en, 0);
            check(g, {tag, "_bit_valid"}, bit_vld, 0);
            check(g, {tag, "_bit_and_idx"}, {bit_o, bit_idx}, 0);
            check(g, {tag, "_addrs"}, {w_addr, x_addr, th_addr}, 0);
            check(g, {tag, "_pc_bus_zero"}, ((pc_data == '0) && (pc_weight == '0)) ? 1 : 0, 1);
        endtask

        task automatic abort_run();
            fill(0, -1);
            begin_layer();
            repeat ((N*C) / 2) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            sb.delete();
            exp_done = -1;
            @(negedge clk);
            rst = 1'b0;
            check_quiet("after_abort");
            repeat (N*C + PL + 6) @(negedge clk);
            check(g, "no_done_after_abort", done_cnt, 0);
        endtask

        initial begin
            rst   = 1'b1;
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            check_quiet("reset");
            fill(1, C*WL); run_layer(1'b0);
            fill(2, 1);    run_layer(1'b0);
            fill(2, 0);    run_layer(1'b0);
            fill(3, -2);   run_layer(1'b0);
            fill(3, -3);   run_layer(1'b0);
            fill(0, -1);   run_layer(1'b1);
            for (int r = 0; r < 4; r++) begin
                fill(0, -1);
                run_layer(1'b0);
            end
            abort_run();
            fill(0, -1);   run_layer(1'b0);
            fin_g = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk);
            if (g_cfg[0].fin_g && g_cfg[1].fin_g && g_cfg[2].fin_g) break;
        end
        if (!(g_cfg[0].fin_g && g_cfg[1].fin_g && g_cfg[2].fin_g))
            check(-1, "bench_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
